// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: accepts one local command, runs it
// on the bus with an STB timeout, and returns one response per command.
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen during the last allowed STB cycle.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  stb_cnt_reg, stb_cnt_next;
    logic        we_reg, we_next;
    logic [3:0]  sel_reg, sel_next;
    logic [31:0] adr_reg, adr_next;
    logic [31:0] dat_reg, dat_next;
    logic [31:0] rsp_dat_reg, rsp_dat_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    logic [7:0]  timeout_count_reg, timeout_count_next;

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_reg         <= IDLE;
            stb_cnt_reg       <= 8'd0;
            we_reg            <= 1'b0;
            sel_reg           <= 4'd0;
            adr_reg           <= 32'd0;
            dat_reg           <= 32'd0;
            rsp_dat_reg       <= 32'd0;
            rsp_timeout_reg   <= 1'b0;
            timeout_count_reg <= 8'd0;
        end else begin
            state_reg         <= state_next;
            stb_cnt_reg       <= stb_cnt_next;
            we_reg            <= we_next;
            sel_reg           <= sel_next;
            adr_reg           <= adr_next;
            dat_reg           <= dat_next;
            rsp_dat_reg       <= rsp_dat_next;
            rsp_timeout_reg   <= rsp_timeout_next;
            timeout_count_reg <= timeout_count_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        stb_cnt_next       = stb_cnt_reg;
        we_next            = we_reg;
        sel_next           = sel_reg;
        adr_next           = adr_reg;
        dat_next           = dat_reg;
        rsp_dat_next       = rsp_dat_reg;
        rsp_timeout_next   = rsp_timeout_reg;
        timeout_count_next = timeout_count_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    we_next      = cmd_we;
                    sel_next     = cmd_sel;
                    adr_next     = cmd_adr;
                    dat_next     = cmd_dat;
                    stb_cnt_next = 8'd0;
                    state_next   = BUS;
                end
            end
            BUS: begin
                // ACK is tested first so it wins over a coincident timeout.
                if (wbm_ack_i) begin
                    rsp_dat_next     = we_reg ? 32'd0 : wbm_dat_i;
                    rsp_timeout_next = 1'b0;
                    state_next       = RESP;
                end else if (stb_cnt_reg == LAST_CNT) begin
                    rsp_dat_next     = 32'd0;
                    rsp_timeout_next = 1'b1;
                    if (timeout_count_reg != 8'hFF) begin
                        timeout_count_next = timeout_count_reg + 8'd1;
                    end
                    state_next = RESP;
                end else begin
                    stb_cnt_next = stb_cnt_reg + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready     = (state_reg == IDLE) && !reset;
    assign wbm_cyc_o     = (state_reg == BUS);
    assign wbm_stb_o     = (state_reg == BUS);
    assign wbm_we_o      = we_reg;
    assign wbm_sel_o     = sel_reg;
    assign wbm_adr_o     = adr_reg;
    assign wbm_dat_o     = dat_reg;
    assign rsp_valid     = (state_reg == RESP);
    assign rsp_dat       = rsp_dat_reg;
    assign rsp_timeout   = rsp_timeout_reg;
    assign timeout_count = timeout_count_reg;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed vector table, randomized
// transfers against a transaction-level model, saturation and reset-abort cases.
module tb_wb_initiator;

    localparam int T = 16;

    logic        wb_clk_i = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [7:0]  timeout_count;

    int checks = 0;
    int errors = 0;
    int model_tc = 0;
    int txn_no = 0;

    wb_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(wb_clk_i), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_timeout(rsp_timeout),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .timeout_count(timeout_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_delay;   // STB cycle in which ACK arrives; 0 = never
        logic [31:0] slave_dat;
        int          rsp_wait;
        int          exp_stb;
        logic [31:0] exp_dat;
        logic        exp_to;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level reference: what a transfer should look like from the outside.
    task automatic model_txn(input logic we, input int ack_delay, input logic [31:0] slave_dat,
                             output int exp_stb, output logic [31:0] exp_dat, output logic exp_to);
        if (ack_delay >= 1 && ack_delay <= T) begin
            exp_stb = ack_delay;
            exp_to  = 1'b0;
            exp_dat = we ? 32'd0 : slave_dat;
        end else begin
            exp_stb = T;
            exp_to  = 1'b1;
            exp_dat = 32'd0;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int n, stb, bad_hold, unstable;
        logic [31:0] held_dat;
        logic held_to;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we  = v.we;
        cmd_adr = v.adr;
        cmd_dat = v.dat;
        cmd_sel = v.sel;
        @(negedge wb_clk_i);
        cmd_we  = ~v.we;
        cmd_adr = $urandom;
        cmd_dat = $urandom;
        cmd_sel = 4'($urandom);
        check("stb_latency", {31'd0, wbm_stb_o}, 32'd1);
        stb = 0;
        bad_hold = 0;
        while (wbm_stb_o === 1'b1 && stb < 300) begin
            stb++;
            if (wbm_cyc_o !== 1'b1 || wbm_we_o !== v.we || wbm_adr_o !== v.adr ||
                wbm_dat_o !== v.dat || wbm_sel_o !== v.sel)
                bad_hold++;
            cmd_valid = 1'($urandom);
            wbm_ack_i = (v.ack_delay != 0) && (stb == v.ack_delay);
            wbm_dat_i = wbm_ack_i ? v.slave_dat : $urandom;
            @(negedge wb_clk_i);
        end
        wbm_ack_i = 1'b0;
        cmd_valid = 1'b0;
        check("stb_cycles", stb, v.exp_stb);
        check("bus_hold", bad_hold, 0);
        check("cyc_after_term", {31'd0, wbm_cyc_o}, 32'd0);
        check("rsp_valid_latency", {31'd0, rsp_valid}, 32'd1);
        check("rsp_dat", rsp_dat, v.exp_dat);
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_to});
        if (v.exp_to) model_tc = (model_tc == 255) ? 255 : model_tc + 1;
        check("timeout_count", {24'd0, timeout_count}, model_tc);
        held_dat = rsp_dat;
        held_to  = rsp_timeout;
        unstable = 0;
        for (int i = 0; i < v.rsp_wait; i++) begin
            cmd_valid = 1'($urandom);
            wbm_ack_i = 1'($urandom);
            wbm_dat_i = $urandom;
            @(negedge wb_clk_i);
            if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_timeout !== held_to ||
                cmd_ready !== 1'b0 || wbm_stb_o !== 1'b0)
                unstable++;
        end
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b0;
        check("rsp_hold", unstable, 0);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        check("rsp_done", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
        txn_no++;
        $display("txn %0d we=%0b adr=%08h ack_delay=%0d stb=%0d rsp_dat=%08h to=%0b tc=%0d",
                 txn_no, v.we, v.adr, v.ack_delay, stb, held_dat, held_to, timeout_count);
    endtask

    initial begin
        vec_t v;
        int stb;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;

        //                we    adr           dat           sel   ack rdat          wait stb dat           to
        vecs[0] = '{1'b0, 32'h0300_0004, 32'h0,         4'hF, 1,  32'h4669_626F, 0,  1,  32'h4669_626F, 1'b0};
        vecs[1] = '{1'b1, 32'h0300_0018, 32'hA5A5_A5A5, 4'hF, 3,  32'hDEAD_BEEF, 0,  3,  32'h0,         1'b0};
        vecs[2] = '{1'b0, 32'h0300_0020, 32'h0,         4'hF, 0,  32'h0,         0,  16, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h0300_002C, 32'h0,         4'hF, 16, 32'h1234_5678, 0,  16, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 32'h0300_0030, 32'h0,         4'h3, 2,  32'hCAFE_F00D, 10, 2,  32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5, 17, 32'h0,         2,  16, 32'h0,         1'b1};
        vecs[6] = '{1'b0, 32'h0000_0044, 32'h0,         4'hC, 17, 32'h5555_AAAA, 0,  16, 32'h0,         1'b1};

        repeat (3) @(negedge wb_clk_i);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_tc", {24'd0, timeout_count}, 32'd0);
        reset = 1'b0;
        @(negedge wb_clk_i);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            v.we        = 1'($urandom);
            v.adr       = $urandom;
            v.dat       = $urandom;
            v.sel       = 4'($urandom);
            v.ack_delay = $urandom_range(0, 20);
            v.slave_dat = $urandom;
            v.rsp_wait  = $urandom_range(0, 4);
            model_txn(v.we, v.ack_delay, v.slave_dat, v.exp_stb, v.exp_dat, v.exp_to);
            run_txn(v);
        end

        // Drive the counter well past saturation.
        for (int i = 0; i < 256; i++) begin
            v.we = 1'($urandom); v.adr = $urandom; v.dat = $urandom; v.sel = 4'($urandom);
            v.ack_delay = 0; v.slave_dat = $urandom; v.rsp_wait = 0;
            model_txn(v.we, v.ack_delay, v.slave_dat, v.exp_stb, v.exp_dat, v.exp_to);
            run_txn(v);
        end
        check("tc_saturated", {24'd0, timeout_count}, 32'd255);

        // Reset in the 5th STB cycle aborts the transfer.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0300_0100; cmd_sel = 4'hF;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        stb = 1;
        while (wbm_stb_o === 1'b1 && stb < 5) begin
            @(negedge wb_clk_i);
            stb++;
        end
        check("abort_reached_stb5", {31'd0, wbm_stb_o}, 32'd1);
        reset = 1'b1;
        @(negedge wb_clk_i);
        check("abort_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("abort_stb", {31'd0, wbm_stb_o}, 32'd0);
        check("abort_cmd_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
        check("abort_tc_cleared", {24'd0, timeout_count}, 32'd0);
        reset = 1'b0;
        model_tc = 0;
        @(negedge wb_clk_i);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        stb = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b0) stb++;
            @(negedge wb_clk_i);
        end
        check("abort_no_rsp", stb, 0);
        $display("reset abort: cyc=%0b rsp_valid=%0b cmd_ready=%0b", wbm_cyc_o, rsp_valid, cmd_ready);

        // First timeout after reset moves the counter 0 -> 1.
        v = vecs[2];
        run_txn(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
